// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its port arbiter:
// widths, arbiter FSM states and the latched request command.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arbStateT;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
        logic [DATA_W-1:0] wdata;
    } reqCmdT;

endpackage

// File: rtl/regfile_port_arbiter_rr.sv
// Two-way round-robin grant: the pointer holder wins a tie, and after an
// enabled grant the pointer passes to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic pointer;

    always_comb begin
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            pointer <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single select-driven register file port between two requesters,
// one access per slot, returning read data as a one-cycle response pulse.
module regfile_port_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr1_0,
    input  logic [ADDR_W-1:0] req_addr1_1,
    input  logic [ADDR_W-1:0] req_addr2_0,
    input  logic [ADDR_W-1:0] req_addr2_1,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              rf_select,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2
);

    arbStateT   state;
    arbStateT   nextState;
    reqCmdT     winCmd;
    logic [1:0] grant;
    logic       grantEn;
    logic       holdWrite;
    logic       owner;

    rr_arbiter2 u_rrArbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (grantEn),
        .grant  (grant)
    );

    always_comb begin
        if (grant[1]) begin
            winCmd = '{write: req_write[1], addr1: req_addr1_1,
                       addr2: req_addr2_1, wdata: req_wdata_1};
        end else begin
            winCmd = '{write: req_write[0], addr1: req_addr1_0,
                       addr2: req_addr2_0, wdata: req_wdata_0};
        end
    end

    // Ready is only offered from IDLE and never while reset is held.
    always_comb begin
        nextState = state;
        grantEn   = 1'b0;
        req_ready = 2'b00;
        unique case (state)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    req_ready = grant;
                    grantEn   = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS:  nextState = holdWrite ? IDLE : RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The rf address/data registers double as the command holding registers,
    // so requester inputs are only sampled in the handshake cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            holdWrite  <= 1'b0;
            owner      <= 1'b0;
            rf_select  <= 1'b1;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
        end else begin
            state     <= nextState;
            rf_select <= 1'b1;
            rsp_valid <= 2'b00;
            if (grantEn) begin
                holdWrite <= winCmd.write;
                owner     <= grant[1];
                if (winCmd.write) begin
                    rf_select <= 1'b0;
                    rf_waddr  <= winCmd.addr1;
                    rf_wdata  <= winCmd.wdata;
                end else begin
                    rf_raddr1 <= winCmd.addr1;
                    rf_raddr2 <= winCmd.addr2;
                end
            end
            if ((state == ACCESS) && !holdWrite) begin
                rsp_rdata1 <= rf_rdata1;
                rsp_rdata2 <= rf_rdata2;
                rsp_valid  <= owner ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a transaction-level model predicts grant order,
// slot timing and read data; every cycle the DUT outputs are compared against it.
module tb_regfile_port_arbiter;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [ADDR_W-1:0] req_addr1_0, req_addr1_1, req_addr2_0, req_addr2_1;
    logic [DATA_W-1:0] req_wdata_0, req_wdata_1, rsp_rdata1, rsp_rdata2;
    logic              rf_select;
    logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [DATA_W-1:0] rf_wdata, rf_rdata1, rf_rdata2;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr1_0 (req_addr1_0),
        .req_addr1_1 (req_addr1_1),
        .req_addr2_0 (req_addr2_0),
        .req_addr2_1 (req_addr2_1),
        .req_wdata_0 (req_wdata_0),
        .req_wdata_1 (req_wdata_1),
        .rsp_valid   (rsp_valid),
        .rsp_rdata1  (rsp_rdata1),
        .rsp_rdata2  (rsp_rdata2),
        .rf_select   (rf_select),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2)
    );

    function automatic logic [DATA_W-1:0] initVal(int i);
        return DATA_W'(i * 257) ^ 16'h5A5A;
    endfunction

    // Register file the DUT drives: writes on the clock edge while select is 0.
    logic              memReady = 1'b0;
    logic [DATA_W-1:0] envMem [32];
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 32; i++) envMem[i] <= initVal(i);
        end else if (!rf_select) begin
            envMem[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata1 = envMem[rf_raddr1];
    assign rf_rdata2 = envMem[rf_raddr2];

    logic [DATA_W-1:0] refMem [32];
    int                cyc, freeCycle, accCycle, rspCycle, lastHsCycle;
    logic              ptr, accWrite, rspOwner;
    logic [ADDR_W-1:0] accA1, accA2, lastWa;
    logic [DATA_W-1:0] lastWd, rspD1, rspD2;
    logic [1:0]        expReady;
    int                grantLog[$];
    int                checks = 0;
    int                errors = 0;
    int                selLowCount = 0;
    logic [1:0]        dutRspValid;
    logic [DATA_W-1:0] dutRspD1;
    int                dutRspCycle;

    logic              pv [2];
    logic              pw [2];
    logic [ADDR_W-1:0] pa1 [2];
    logic [ADDR_W-1:0] pa2 [2];
    logic [DATA_W-1:0] pd [2];

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void modelReset();
        cyc       = 0;
        freeCycle = 0;
        accCycle  = -1;
        rspCycle  = -1;
        ptr       = 1'b0;
        accWrite  = 1'b0;
        accA1     = '0;
        accA2     = '0;
        lastWa    = '0;
        lastWd    = '0;
        expReady  = 2'b00;
        for (int r = 0; r < 2; r++) pv[r] = 1'b0;
    endfunction

    function automatic void issue(int r, logic w, logic [ADDR_W-1:0] a1,
                                  logic [ADDR_W-1:0] a2, logic [DATA_W-1:0] d);
        pv[r]  = 1'b1;
        pw[r]  = w;
        pa1[r] = a1;
        pa2[r] = a2;
        pd[r]  = d;
    endfunction

    function automatic bit busy();
        return pv[0] || pv[1] || (cyc < freeCycle) || (cyc <= rspCycle);
    endfunction

    // Idle requesters present garbage so nothing is latched without a handshake.
    task automatic applyStimulus();
        logic [1:0]        v, w;
        logic [ADDR_W-1:0] a1 [2];
        logic [ADDR_W-1:0] a2 [2];
        logic [DATA_W-1:0] d [2];
        for (int r = 0; r < 2; r++) begin
            v[r]  = pv[r];
            w[r]  = pv[r] ? pw[r]  : 1'($urandom);
            a1[r] = pv[r] ? pa1[r] : ADDR_W'($urandom);
            a2[r] = pv[r] ? pa2[r] : ADDR_W'($urandom);
            d[r]  = pv[r] ? pd[r]  : DATA_W'($urandom);
        end
        req_valid   = v;
        req_write   = w;
        req_addr1_0 = a1[0];
        req_addr1_1 = a1[1];
        req_addr2_0 = a2[0];
        req_addr2_1 = a2[1];
        req_wdata_0 = d[0];
        req_wdata_1 = d[1];
    endtask

    task automatic checkOutput();
        int win;
        expReady = 2'b00;
        if ((cyc >= freeCycle) && (pv[0] || pv[1])) begin
            win = (pv[0] && pv[1]) ? (ptr ? 1 : 0) : (pv[1] ? 1 : 0);
            expReady[win] = 1'b1;
        end
        compare("req_ready", req_ready, expReady);
        compare("rf_select", rf_select, ((accCycle == cyc) && accWrite) ? 0 : 1);
        compare("rf_waddr", rf_waddr, lastWa);
        compare("rf_wdata", rf_wdata, lastWd);
        compare("rsp_valid", rsp_valid, (rspCycle == cyc) ? (rspOwner ? 2 : 1) : 0);
        if ((accCycle == cyc) && !accWrite) begin
            compare("rf_raddr1", rf_raddr1, accA1);
            compare("rf_raddr2", rf_raddr2, accA2);
        end
        if (rspCycle == cyc) begin
            compare("rsp_rdata1", rsp_rdata1, rspD1);
            compare("rsp_rdata2", rsp_rdata2, rspD2);
        end
        if (rsp_valid != 2'b00) begin
            dutRspValid = rsp_valid;
            dutRspD1    = rsp_rdata1;
            dutRspCycle = cyc;
        end
        if (!rf_select) selLowCount++;
    endtask

    // Serialized slots mean every earlier write has landed before a later grant.
    task automatic modelUpdate();
        int r;
        if (expReady != 2'b00) begin
            r = expReady[1] ? 1 : 0;
            grantLog.push_back(r);
            lastHsCycle = cyc;
            pv[r]    = 1'b0;
            ptr      = (r == 0);
            accCycle = cyc + 1;
            accWrite = pw[r];
            if (pw[r]) begin
                refMem[pa1[r]] = pd[r];
                lastWa    = pa1[r];
                lastWd    = pd[r];
                freeCycle = cyc + 2;
            end else begin
                accA1     = pa1[r];
                accA2     = pa2[r];
                rspD1     = refMem[pa1[r]];
                rspD2     = refMem[pa2[r]];
                rspOwner  = (r == 1);
                rspCycle  = cyc + 2;
                freeCycle = cyc + 3;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        applyStimulus();
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic runUntilQuiet(string tag, int maxCycles);
        int n = 0;
        while (busy() && (n < maxCycles)) begin
            tick();
            n++;
        end
        if (busy()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected idle", tag, maxCycles);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        compare("rst_req_ready", req_ready, 0);
        compare("rst_rf_select", rf_select, 1);
        compare("rst_rf_raddr1", rf_raddr1, 0);
        compare("rst_rf_raddr2", rf_raddr2, 0);
        compare("rst_rf_waddr", rf_waddr, 0);
        compare("rst_rf_wdata", rf_wdata, 0);
        compare("rst_rsp_valid", rsp_valid, 0);
        compare("rst_rsp_rdata1", rsp_rdata1, 0);
        compare("rst_rsp_rdata2", rsp_rdata2, 0);
        @(posedge clk);
        @(negedge clk);
        compare("rst_rsp_valid_held", rsp_valid, 0);
        modelReset();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gStart;
        int n;
        rst_n       = 1'b1;
        req_valid   = 2'b00;
        req_write   = 2'b00;
        req_addr1_0 = '0;
        req_addr1_1 = '0;
        req_addr2_0 = '0;
        req_addr2_1 = '0;
        req_wdata_0 = '0;
        req_wdata_1 = '0;
        for (int i = 0; i < 32; i++) refMem[i] = initVal(i);
        modelReset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        memReady = 1'b1;
        doReset();

        $display("[TB] write 10 to r3, 15 to r1, then read r1/r3");
        issue(0, 1'b1, 5'd3, 5'd0, 16'd10);
        runUntilQuiet("write_r3", 20);
        issue(0, 1'b1, 5'd1, 5'd0, 16'd15);
        runUntilQuiet("write_r1", 20);
        issue(0, 1'b0, 5'd1, 5'd3, 16'd0);
        runUntilQuiet("read_r1_r3", 20);
        compare("pin_read_rdata1", rspD1, 16'd15);
        compare("pin_read_rdata2", rspD2, 16'd10);
        compare("dut_read_rdata1", dutRspD1, 16'd15);
        compare("dut_read_owner", dutRspValid, 2'b01);
        compare("dut_read_latency", dutRspCycle - lastHsCycle, 2);

        $display("[TB] contention after reset");
        doReset();
        gStart = grantLog.size();
        n = 0;
        while ((grantLog.size() < gStart + 4) && (n < 40)) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r]) issue(r, 1'b1, ADDR_W'(8 + r), 5'd0, DATA_W'($urandom));
            tick();
            n++;
        end
        runUntilQuiet("contention_drain", 20);
        if (grantLog.size() < gStart + 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL contention_grants: got %0d grants, expected 4", grantLog.size() - gStart);
        end else begin
            for (int k = 0; k < 4; k++) compare("pin_contention_order", grantLog[gStart + k], k % 2);
        end

        $display("[TB] back-to-back writes to r31 from requester 1");
        selLowCount = 0;
        issue(1, 1'b1, 5'd31, 5'd0, 16'hABCD);
        n = 0;
        while (pv[1] && (n < 10)) begin
            tick();
            n++;
        end
        issue(1, 1'b1, 5'd31, 5'd0, 16'h0001);
        runUntilQuiet("b2b_writes", 20);
        compare("b2b_select_low_cycles", selLowCount, 2);
        issue(1, 1'b0, 5'd31, 5'd31, 16'd0);
        runUntilQuiet("b2b_read", 20);
        compare("pin_b2b_rdata", rspD1, 16'h0001);
        compare("dut_b2b_rdata", dutRspD1, 16'h0001);

        $display("[TB] write-then-read hazard on r5");
        doReset();
        issue(0, 1'b1, 5'd5, 5'd0, 16'd7);
        issue(1, 1'b0, 5'd5, 5'd5, 16'd0);
        runUntilQuiet("hazard", 20);
        compare("pin_hazard_owner", rspOwner, 1);
        compare("pin_hazard_rdata", rspD1, 16'd7);
        compare("dut_hazard_rdata", dutRspD1, 16'd7);
        compare("dut_hazard_owner", dutRspValid, 2'b10);

        $display("[TB] reset during a read access");
        issue(1, 1'b0, 5'd1, 5'd3, 16'd0);
        n = 0;
        while (pv[1] && (n < 10)) begin
            tick();
            n++;
        end
        doReset();
        gStart = grantLog.size();
        issue(0, 1'b0, 5'd2, 5'd4, 16'd0);
        issue(1, 1'b0, 5'd6, 5'd7, 16'd0);
        runUntilQuiet("post_reset", 20);
        compare("pin_post_reset_first", grantLog[gStart], 0);

        $display("[TB] idle hold");
        selLowCount = 0;
        repeat (10) tick();
        compare("idle_select_low", selLowCount, 0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pv[r] && ($urandom_range(0, 1) == 1))
                    issue(r, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                          ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
            tick();
        end
        runUntilQuiet("random_drain", 20);
        for (int i = 0; i < 32; i++) compare("final_mem", envMem[i], refMem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
